// File: rtl/red_pkg.sv
// Shared types and helpers for the nibble-serial reduction-add unit.
package red_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NIBBLES = 4;
    localparam int RES_W   = 7;

    function automatic logic [3:0] nib(input logic [15:0] x, input logic [1:0] i);
        return x[{i, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/red_nib_accum.sv
// Combinational step of the reduction: adds NIB_PER_CYCLE nibble pairs
// (selected by cnt) to the running 7-bit accumulator.
module red_nib_accum
    import red_pkg::*;
#(
    parameter int NIB_PER_CYCLE = 1
) (
    input  logic [RES_W-1:0] acc,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    input  logic [1:0]       cnt,
    output logic [RES_W-1:0] acc_next
);

    if (!(NIB_PER_CYCLE == 1 || NIB_PER_CYCLE == 2 || NIB_PER_CYCLE == 4)) begin : g_bad_width
        $error("red_nib_accum: NIB_PER_CYCLE must be 1, 2 or 4");
    end

    // 4-bit carry-lookahead adder; the 5-bit result is one nibble-pair sum.
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] g;
        logic [3:0] p;
        logic [4:0] c;
        g    = x & y;
        p    = x ^ y;
        c[0] = 1'b0;
        c[1] = g[0];
        c[2] = g[1] | (p[1] & g[0]);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {c[4], p ^ c[3:0]};
    endfunction

    logic [RES_W-1:0] group_sum;
    logic [1:0]       idx;

    always_comb begin
        group_sum = '0;
        idx       = '0;
        for (int k = 0; k < NIB_PER_CYCLE; k++) begin
            idx       = 2'(int'(cnt) * NIB_PER_CYCLE + k);
            group_sum = group_sum + RES_W'(cla4(nib(a, idx), nib(b, idx)));
        end
        acc_next = acc + group_sum;
    end

endmodule

// File: rtl/red_serial_unit.sv
// Multi-cycle RED operation: sums all eight nibbles of A and B, iterating
// NIB_PER_CYCLE nibble pairs per cycle behind valid/ready handshakes.
module red_serial_unit
    import red_pkg::*;
#(
    parameter int NIB_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] S,
    output logic        busy
);

    localparam int         ACCUM_CYCLES = NIBBLES / NIB_PER_CYCLE;
    localparam logic [1:0] LAST_CNT     = 2'(ACCUM_CYCLES - 1);

    state_t           state;
    logic [1:0]       cnt;
    logic [RES_W-1:0] acc;
    logic [RES_W-1:0] acc_next;
    logic [15:0]      a_reg;
    logic [15:0]      b_reg;

    red_nib_accum #(
        .NIB_PER_CYCLE(NIB_PER_CYCLE)
    ) u_accum (
        .acc      (acc),
        .a        (a_reg),
        .b        (b_reg),
        .cnt      (cnt),
        .acc_next (acc_next)
    );

    // flush outranks both a new request and a pending result handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
            a_reg <= '0;
            b_reg <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= A;
                        b_reg <= B;
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc_next;
                    cnt <= cnt + 2'd1;
                    if (cnt == LAST_CNT) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode the state register directly so reset clears them at once.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign S         = out_valid ? 16'(acc) : 16'd0;

endmodule

// File: tb/tb_red_serial_unit.sv
// Scoreboard bench: three instances (1, 2 and 4 nibble pairs per cycle) share
// stimulus; a transaction-level model predicts results, latency and handshakes.
module tb_red_serial_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        flush;
    logic        out_ready;
    logic [2:0]  in_ready_v;
    logic [2:0]  out_valid_v;
    logic [2:0]  busy_v;
    logic [15:0] s_v [3];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          edge_cnt = 0;

    int          lat [3] = '{4, 2, 1};
    int          npc [3] = '{1, 2, 4};
    bit          pend [3];
    int          acc_edge [3];
    logic [15:0] exp_q [3][$];

    red_serial_unit #(.NIB_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .A(a), .B(b), .flush(flush), .out_valid(out_valid_v[0]),
        .out_ready(out_ready), .S(s_v[0]), .busy(busy_v[0])
    );
    red_serial_unit #(.NIB_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .A(a), .B(b), .flush(flush), .out_valid(out_valid_v[1]),
        .out_ready(out_ready), .S(s_v[1]), .busy(busy_v[1])
    );
    red_serial_unit #(.NIB_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .A(a), .B(b), .flush(flush), .out_valid(out_valid_v[2]),
        .out_ready(out_ready), .S(s_v[2]), .busy(busy_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [15:0] ref_red(input logic [15:0] x, input logic [15:0] y);
        int sum = 0;
        for (int i = 0; i < 4; i++) begin
            sum += int'((x >> (4 * i)) & 16'hF) + int'((y >> (4 * i)) & 16'hF);
        end
        return 16'(sum);
    endfunction

    task automatic chk(input string name, input int i, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s npc=%0d t=%0t: got %h expected %h", name, npc[i], $time, act, exp);
        end
    endtask

    // Monitor: compares every cycle, then advances the model for the coming edge.
    initial begin
        for (int i = 0; i < 3; i++) begin
            pend[i]     = 1'b0;
            acc_edge[i] = 0;
        end
        #1;
        forever begin
            @(negedge clk or posedge rst);
            if (clk && rst) begin
                #1;
                for (int i = 0; i < 3; i++) begin
                    chk("async_rst_out_valid", i, 16'(out_valid_v[i]), 16'd0);
                    chk("async_rst_busy", i, 16'(busy_v[i]), 16'd0);
                    chk("async_rst_in_ready", i, 16'(in_ready_v[i]), 16'd1);
                    chk("async_rst_S", i, s_v[i], 16'd0);
                    pend[i] = 1'b0;
                    exp_q[i].delete();
                end
            end else begin
                for (int i = 0; i < 3; i++) begin
                    bit          ev;
                    logic [15:0] es;
                    ev = pend[i] && (edge_cnt >= acc_edge[i] + lat[i]);
                    es = (ev && exp_q[i].size() > 0) ? exp_q[i][0] : 16'h0;
                    chk("out_valid", i, 16'(out_valid_v[i]), 16'(ev));
                    chk("in_ready", i, 16'(in_ready_v[i]), 16'(!pend[i]));
                    chk("busy", i, 16'(busy_v[i]), 16'(pend[i]));
                    chk("S", i, s_v[i], es);
                    if (rst) begin
                        pend[i] = 1'b0;
                        exp_q[i].delete();
                    end else if (flush) begin
                        pend[i] = 1'b0;
                        exp_q[i].delete();
                    end else if (pend[i]) begin
                        if (ev && out_ready) begin
                            void'(exp_q[i].pop_front());
                            pend[i] = 1'b0;
                        end
                    end else if (in_valid) begin
                        exp_q[i].push_back(ref_red(a, b));
                        pend[i]     = 1'b1;
                        acc_edge[i] = edge_cnt + 1;
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input bit rnd);
        int n = 0;
        while (!(&in_ready_v)) begin
            if (rnd) begin
                out_ready = 1'($urandom_range(0, 1));
                flush     = ($urandom_range(0, 19) == 0);
            end
            cyc();
            n++;
            if (n > 200) begin
                $display("FAIL wait_idle timeout: in_ready=%b expected 111", in_ready_v);
                $fatal(1, "bench timeout");
            end
        end
    endtask

    task automatic issue(input logic [15:0] xa, input logic [15:0] xb, input bit rnd);
        wait_idle(rnd);
        a        = xa;
        b        = xb;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
    endtask

    initial begin
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc();

        // Full-scale operands
        issue(16'hFFFF, 16'hFFFF, 1'b0);
        wait_idle(1'b0);

        // Back-to-back mixed and zero operands
        issue(16'h1234, 16'h5678, 1'b0);
        issue(16'h0000, 16'h0000, 1'b0);
        wait_idle(1'b0);

        // Result held while the consumer stalls
        out_ready = 1'b0;
        issue(16'h00F1, 16'h1000, 1'b0);
        n = 0;
        while (!out_valid_v[0] && n < 20) begin
            cyc();
            n++;
        end
        repeat (3) cyc();
        out_ready = 1'b1;
        wait_idle(1'b0);

        // Flush mid-run, then a clean follow-up
        issue(16'hFFFF, 16'hFFFF, 1'b0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        issue(16'h1111, 16'h1111, 1'b0);
        wait_idle(1'b0);

        // Asynchronous reset mid-accumulation
        issue(16'hFFFF, 16'hFFFF, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        cyc();

        // Request during busy is ignored
        issue(16'hABCD, 16'h0F0F, 1'b0);
        a        = 16'h2222;
        b        = 16'h2222;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        wait_idle(1'b0);

        // Randomized traffic with random backpressure and flushes
        for (int t = 0; t < 40; t++) begin
            issue(16'($urandom), 16'($urandom), 1'b1);
        end
        flush     = 1'b0;
        out_ready = 1'b1;
        wait_idle(1'b0);
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
